// File: rtl/onehot_decoder.sv
// onehot_decoder
//   Registered 3-to-8 one-hot decoder with a valid/ready input handshake and a
//   programmable output hold time. An accepted code drives exactly one line of
//   `out` for max(hold_len,1) cycles. A single all-zero gap cycle follows, so
//   two loads are never selected at the same time (break-before-make).
//
//   Code bit order matches the 8-to-3 `encoder`:
//   index = 4*in_code[0] + 2*in_code[1] + in_code[2].
//
// Ports
//   clk       in   clock, rising edge
//   rst_n     in   synchronous active-low reset
//   in_valid  in   in_code is valid this cycle
//   in_code   in   [2:0] code to decode (encoder bit order)
//   hold_len  in   [HOLD_W-1:0] hold cycles, sampled on acceptance, 0 acts as 1
//   in_ready  out  block can accept a code this cycle (never depends on in_valid)
//   out       out  [7:0] registered one-hot line or all zeros
//   out_valid out  registered, high exactly when out != 0
//   busy      out  registered, high in DRIVE or GAP
//
// Configuration
//   ONEHOT_DECODER_QUEUE_EN : when defined, adds a one-entry pending slot
//   (code + hold length). A code can then be accepted during DRIVE/GAP and
//   starts straight after the current gap.
module onehot_decoder #(
   parameter int HOLD_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [2:0]        in_code,
   input  logic [HOLD_W-1:0] hold_len,
   output logic              in_ready,
   output logic [7:0]        out,
   output logic              out_valid,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t            state;
   logic [HOLD_W-1:0] cnt;
   logic              accept;

`ifdef ONEHOT_DECODER_QUEUE_EN
   logic              pend_valid;
   logic [2:0]        pend_code;
   logic [HOLD_W-1:0] pend_hold;
`endif

   // Encoder bit order: in_code[0] is the MSB of the line index.
   function automatic logic [7:0] decode_onehot(input logic [2:0] code);
      logic [2:0] idx;
      idx = {code[0], code[1], code[2]};
      decode_onehot = 8'h01 << idx;
   endfunction

   // Counter preload is max(h,1)-1, so a zero hold behaves like a hold of one.
   function automatic logic [HOLD_W-1:0] hold_load(input logic [HOLD_W-1:0] h);
      if (h == HOLD_W'(0)) begin
         hold_load = HOLD_W'(0);
      end else begin
         hold_load = h - HOLD_W'(1);
      end
   endfunction

   // Ready decode from state / slot occupancy only; forced low during reset.
   always_comb begin
      in_ready = 1'b0;
      if (!rst_n) begin
         in_ready = 1'b0;
      end else begin
`ifdef ONEHOT_DECODER_QUEUE_EN
         // A full slot also covers the GAP->DRIVE consume cycle.
         in_ready = ~pend_valid;
`else
         in_ready = (state == IDLE);
`endif
      end
   end

   assign accept = in_valid & in_ready;

   // State machine, hold counter, pending slot and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= HOLD_W'(0);
         out       <= 8'h00;
         out_valid <= 1'b0;
         busy      <= 1'b0;
`ifdef ONEHOT_DECODER_QUEUE_EN
         pend_valid <= 1'b0;
         pend_code  <= 3'b000;
         pend_hold  <= HOLD_W'(0);
`endif
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state     <= DRIVE;
                  cnt       <= hold_load(hold_len);
                  out       <= decode_onehot(in_code);
                  out_valid <= 1'b1;
                  busy      <= 1'b1;
               end else begin
                  out       <= 8'h00;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
               end
            end

            DRIVE: begin
               if (cnt != HOLD_W'(0)) begin
                  cnt <= cnt - HOLD_W'(1);
               end else begin
                  state     <= GAP;
                  out       <= 8'h00;
                  out_valid <= 1'b0;
               end
`ifdef ONEHOT_DECODER_QUEUE_EN
               if (accept) begin
                  pend_valid <= 1'b1;
                  pend_code  <= in_code;
                  pend_hold  <= hold_len;
               end
`endif
            end

            GAP: begin
`ifdef ONEHOT_DECODER_QUEUE_EN
               if (pend_valid) begin
                  // Consume the slot; in_ready is low this cycle.
                  state      <= DRIVE;
                  cnt        <= hold_load(pend_hold);
                  out        <= decode_onehot(pend_code);
                  out_valid  <= 1'b1;
                  busy       <= 1'b1;
                  pend_valid <= 1'b0;
               end else if (accept) begin
                  // Code arriving in an empty-slot gap goes straight to DRIVE.
                  state     <= DRIVE;
                  cnt       <= hold_load(hold_len);
                  out       <= decode_onehot(in_code);
                  out_valid <= 1'b1;
                  busy      <= 1'b1;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
`else
               state <= IDLE;
               busy  <= 1'b0;
`endif
            end

            default: begin
               state     <= IDLE;
               cnt       <= HOLD_W'(0);
               out       <= 8'h00;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/onehot_decoder.md
# onehot_decoder

Registered 3-to-8 one-hot decoder with a valid/ready input handshake and a programmable output hold time. It is the receive-side counterpart of the 8-to-3 `encoder`: it accepts a 3-bit code in the same bit ordering the `encoder` produces. It drives exactly one output line for a set number of cycles, then a one-cycle all-zero gap (break-before-make). It sits between control logic that issues codes and one-hot-selected loads (LED banks, mux selects, strobes).

## Interface
- `HOLD_W`, default 4: width of the hold-length input and of the internal hold counter.
- `clk` input 1: clock; all state changes on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `in_valid` input 1: `in_code` is valid this cycle.
- `in_code` input 3: code to decode, in `encoder` bit order.
- `hold_len` input HOLD_W: output hold time in cycles; sampled only on acceptance; 0 is treated as 1.
- `in_ready` output 1: block can accept a code this cycle.
- `out` output 8: one-hot decoded line, or all zeros.
- `out_valid` output 1: high exactly when `out` is non-zero.
- `busy` output 1: high in DRIVE or GAP.

## Operation
- Bit ordering is fixed by the `encoder`: `in_code[0]` has weight 4, `in_code[1]` has weight 2, `in_code[2]` has weight 1.
  - Index = 4·`in_code[0]` + 2·`in_code[1]` + `in_code[2]`.
  - `out[index]` = 1.
  - Example: `in_code`=3'b001 gives `out`=8'h10.
- Acceptance occurs on a rising edge where `in_valid & in_ready` = 1. At that edge the block latches `in_code` and `hold_len`.
- The state machine has three states: IDLE, DRIVE and GAP.
  - IDLE: `in_ready`=1, `out`=0. On acceptance, go to DRIVE. Load the counter with max(`hold_len`,1)−1.
  - DRIVE: `out` = one-hot of the latched code, `out_valid`=1.
    - While the counter ≠ 0, decrement it.
    - When the counter = 0, go to GAP.
  - GAP: `out`=0, `out_valid`=0 for exactly one cycle.
    - Then go to IDLE.
    - Or, with the queue compiled in and an entry pending, go to DRIVE directly with the pending code.
- `in_valid` while `in_ready`=0 is ignored. The upstream side must hold `in_code` stable until it is accepted.
- `in_code` and `hold_len` changing during DRIVE have no effect on the active output.
- Reset (`rst_n`=0 at an edge), including mid-DRIVE or mid-GAP:
  - Next state is IDLE.
  - `out`=8'h00, `out_valid`=0, `busy`=0, counter=0.
  - The pending entry is cleared.
  - `in_ready` is forced to 0 while `rst_n` is low.

## Timing
- Reset values: `out`=8'h00, `out_valid`=0, `busy`=0, `in_ready`=0 (while in reset), then 1 in IDLE.
- Latency: code accepted at edge N means `out` is valid from cycle N+1.
- `out` is held for H = max(`hold_len`,1) cycles, i.e. cycles N+1 … N+H.
- Gap cycle is N+H+1.
- Without the queue, `in_ready` returns to 1 at cycle N+H+2, so back-to-back period = H+2 cycles.
- `out`, `out_valid` and `busy` are registered.
- `in_ready` is a combinational decode of the state and the queue occupancy only; it never depends on `in_valid`.
- `hold_len` = 2^HOLD_W−1 gives the maximum hold. The counter never wraps.

## Configuration
- `ONEHOT_DECODER_QUEUE_EN` defined:
  - Adds a one-entry pending register (code + hold length).
  - `in_ready`=1 in any non-reset state whose pending slot is empty.
  - A code accepted during DRIVE or GAP is stored in the slot. It starts in DRIVE right after the current GAP, giving a back-to-back period of H+1 cycles.
  - Acceptance in the cycle the slot is being consumed (the GAP→DRIVE transition) is not allowed: `in_ready`=0 in that cycle.
- `ONEHOT_DECODER_QUEUE_EN` undefined:
  - No pending register.
  - `in_ready`=1 only in IDLE.

## Test plan
- Reset, then `in_code`=3'b001, `hold_len`=3, `in_valid` for one cycle:
  - `out`=8'h10 for exactly 3 cycles starting the next cycle.
  - Then one cycle of 8'h00.
  - Then `in_ready`=1.
- Sweep all 8 codes with `hold_len`=1:
  - 3'b000→8'h01, 3'b100→8'h02, 3'b010→8'h04, 3'b110→8'h08, 3'b001→8'h10, 3'b101→8'h20, 3'b011→8'h40, 3'b111→8'h80.
  - `out_valid` matches `out`≠0.
- `hold_len`=0 with code 3'b111: `out`=8'h80 for exactly 1 cycle, then the gap.
- Assert `rst_n`=0 in the 2nd cycle of a `hold_len`=5 drive of 3'b011: the next cycle shows `out`=0, `busy`=0, and no further output.
- Hold `in_valid` high with changing codes during DRIVE:
  - Without the queue, the codes are ignored until IDLE.
  - With `ONEHOT_DECODER_QUEUE_EN`, the first code arriving during DRIVE is accepted and driven immediately after the gap (3'b000 then 3'b111 gives 8'h01 ×H, 8'h00, 8'h80 ×H).
- Maximum `hold_len` (15 at `HOLD_W`=4): `out` is held for exactly 15 cycles with no counter wrap or early release.
